// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 8-bit ALU: operand read with result forwarding,
// registered ALU inputs, and commit of the ALU result and flags one edge later.
module alu_issue_stage #(
  parameter int unsigned NUM_REGS = 8,
  parameter bit          R0_ZERO  = 1'b1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [7:0]    in_imm,
  input  logic          in_use_imm,
  input  logic          hold,
  output logic [3:0]    alu_operation,
  output logic [7:0]    alu_operand1,
  output logic [7:0]    alu_operand2,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          alu_carry,
  input  logic          alu_negative,
  output logic [3:0]    flags,
  output logic          commit_valid,
  output logic [AW-1:0] commit_rd,
  output logic [7:0]    commit_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic          e_valid_q, e_valid_d;
  logic [AW-1:0] e_rd_q, e_rd_d;
  logic [3:0]    op_q, op_d;
  logic [7:0]    opa_q, opa_d;
  logic [7:0]    opb_q, opb_d;
  logic [3:0]    flags_q, flags_d;
  logic [7:0]    rf_q [NUM_REGS];

  logic          accept;
  logic          commit;
  logic          wr_en;
  logic [7:0]    rs1_val;
  logic [7:0]    rs2_val;

  // The instruction committing on this edge is the only possible RAW source,
  // so a single bypass from alu_result removes every hazard.
  function automatic logic [7:0] fwd(input logic [AW-1:0] r,
                                     input logic          ev,
                                     input logic [AW-1:0] erd,
                                     input logic [7:0]    res,
                                     input logic [7:0]    rf_val);
    if (R0_ZERO && (r == '0))
      return '0;
    else if (ev && (erd == r))
      return res;
    else
      return rf_val;
  endfunction

  assign accept = in_valid && !hold;
  assign commit = e_valid_q && !hold;
  assign wr_en  = commit && !(R0_ZERO && (e_rd_q == '0));

  always_comb begin
    rs1_val = fwd(in_rs1, e_valid_q, e_rd_q, alu_result, rf_q[in_rs1]);
    rs2_val = fwd(in_rs2, e_valid_q, e_rd_q, alu_result, rf_q[in_rs2]);
  end

  always_comb begin
    e_valid_d = e_valid_q;
    e_rd_d    = e_rd_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    flags_d   = flags_q;
    if (commit)
      flags_d = {alu_negative, alu_carry, alu_overflow, alu_zero};
    if (accept) begin
      e_valid_d = 1'b1;
      e_rd_d    = in_rd;
      op_d      = in_op;
      opa_d     = rs1_val;
      opb_d     = in_use_imm ? in_imm : rs2_val;
    end else if (!hold) begin
      e_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_rd_q    <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      flags_q   <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      flags_q   <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[e_rd_q] <= alu_result;
    end
  end

  assign in_ready      = !hold;
  assign alu_operation = op_q;
  assign alu_operand1  = opa_q;
  assign alu_operand2  = opb_q;
  assign flags         = flags_q;
  assign commit_valid  = commit;
  assign commit_rd     = e_rd_q;
  assign commit_data   = alu_result;
  assign dbg_data      = (R0_ZERO && (dbg_addr == '0)) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU stub, directed scenarios, and a
// randomized run against an in-order architectural model.
module tb_alu_issue_stage;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_use_imm, hold;
  logic [3:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm;
  logic [3:0] alu_operation;
  logic [7:0] alu_operand1, alu_operand2, alu_result;
  logic       alu_zero, alu_overflow, alu_carry, alu_negative;
  logic [3:0] flags;
  logic       commit_valid;
  logic [2:0] commit_rd;
  logic [7:0] commit_data;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [11:0] alu_bus;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    logic [3:0] fl;
  } rec_t;

  // Returns {N,C,V,Z,result}
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; r = 8'h00; s = 9'h000;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_SHL: r = a << b[2:0];
      OP_SHR: r = a >> b[2:0];
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {r[7], c, v, (r == 8'h00), r};
  endfunction

  assign alu_bus = alu_model(alu_operation, alu_operand1, alu_operand2);
  assign {alu_negative, alu_carry, alu_overflow, alu_zero, alu_result} = alu_bus;

  always #5 clk = ~clk;

  alu_issue_stage #(.NUM_REGS(8), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .hold(hold),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry), .alu_negative(alu_negative),
    .flags(flags), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input logic ui);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = ui;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; hold = 1'b0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_use_imm = 1'b0; dbg_addr = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({flags, commit_valid, alu_operation, alu_operand1, alu_operand2} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got flags=%b cv=%b op=%h a=%h b=%h required all 0",
               flags, commit_valid, alu_operation, alu_operand1, alu_operand2);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (flags !== 4'b0000 || commit_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got flags=%b cv=%b rdy=%b required 0000/0/1",
               flags, commit_valid, in_ready);
    end
    for (int a = 0; a < 8; a++) begin
      @(negedge clk) dbg_addr = 3'(a);
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_dbg r%0d got %h required 00", a, dbg_data);
      end
    end
  endtask

  task automatic test_forward();
    @(posedge clk); #1;
    drive(OP_ADD, 3'd1, 3'd0, 3'd0, 8'd5, 1'b1);
    @(posedge clk); #1;
    drive(OP_ADD, 3'd2, 3'd1, 3'd0, 8'd3, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1 || commit_valid !== 1'b1 || commit_rd !== 3'd1 || commit_data !== 8'h05) begin
      failures++;
      $display("FAIL fwd_commit1 got rdy=%b cv=%b rd=%0d data=%h required 1/1/1/05",
               in_ready, commit_valid, commit_rd, commit_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || commit_valid !== 1'b1 || commit_rd !== 3'd2 || commit_data !== 8'h08) begin
      failures++;
      $display("FAIL fwd_commit2 got rdy=%b cv=%b rd=%0d data=%h required 1/1/2/08",
               in_ready, commit_valid, commit_rd, commit_data);
    end
    @(posedge clk); #1;
    dbg_addr = 3'd1; #1;
    checks++;
    if (dbg_data !== 8'h05) begin
      failures++; $display("FAIL fwd_r1 got %h required 05", dbg_data);
    end
    dbg_addr = 3'd2; #1;
    checks++;
    if (dbg_data !== 8'h08 || flags !== 4'b0000 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwd_r2 got r2=%h flags=%b cv=%b required 08/0000/0", dbg_data, flags, commit_valid);
    end
  endtask

  task automatic test_sub();
    @(posedge clk); #1;
    drive(OP_SUB, 3'd3, 3'd1, 3'd1, 8'h00, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    dbg_addr = 3'd3; #1;
    checks++;
    if (dbg_data !== 8'h00 || flags !== 4'b0101) begin
      failures++;
      $display("FAIL sub_zero got r3=%h flags=%b required 00/0101", dbg_data, flags);
    end
  endtask

  task automatic test_overflow_r0();
    @(posedge clk); #1;
    drive(OP_ADD, 3'd5, 3'd0, 3'd0, 8'h7F, 1'b1);
    @(posedge clk); #1;
    drive(OP_ADD, 3'd4, 3'd5, 3'd0, 8'h01, 1'b1);
    @(posedge clk); #1;
    drive(OP_ADD, 3'd0, 3'd4, 3'd0, 8'h00, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (flags !== 4'b1010) begin
      failures++; $display("FAIL ovf_flags got %b required 1010", flags);
    end
    @(posedge clk); #1;
    dbg_addr = 3'd0; #1;
    checks++;
    if (dbg_data !== 8'h00 || flags !== 4'b1000) begin
      failures++;
      $display("FAIL r0_write got r0=%h flags=%b required 00/1000", dbg_data, flags);
    end
    dbg_addr = 3'd4; #1;
    checks++;
    if (dbg_data !== 8'h80) begin
      failures++; $display("FAIL ovf_r4 got %h required 80", dbg_data);
    end
  endtask

  task automatic test_hold();
    int ncommit;
    @(posedge clk); #1;
    drive(OP_OR, 3'd6, 3'd0, 3'd0, 8'hA5, 1'b1);
    @(posedge clk); #1;
    hold = 1'b1;
    drive(OP_ADD, 3'd7, 3'd0, 3'd0, 8'h11, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_comb got rdy=%b cv=%b required 0/0", in_ready, commit_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dbg_addr = 3'd6; #1;
      checks++;
      if (dbg_data !== 8'h00 || flags !== 4'b1000 || commit_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_frozen cyc%0d got r6=%h flags=%b cv=%b required 00/1000/0",
                 i, dbg_data, flags, commit_valid);
      end
    end
    hold = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b1 || commit_rd !== 3'd6 || commit_data !== 8'hA5) begin
      failures++;
      $display("FAIL hold_release got cv=%b rd=%0d data=%h required 1/6/a5",
               commit_valid, commit_rd, commit_data);
    end
    ncommit = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (commit_valid === 1'b1) ncommit++;
    end
    dbg_addr = 3'd6; #1;
    checks++;
    if (dbg_data !== 8'hA5 || ncommit != 0) begin
      failures++;
      $display("FAIL hold_once got r6=%h extra_commits=%0d required a5/0", dbg_data, ncommit);
    end
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 8'h00) begin
      failures++; $display("FAIL hold_noaccept got r7=%h required 00", dbg_data);
    end
  endtask

  task automatic test_reset_inflight();
    int ncommit;
    @(posedge clk); #1;
    drive(OP_XOR, 3'd7, 3'd6, 3'd0, 8'h3C, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (commit_valid !== 1'b0 || flags !== 4'b0000 || alu_operand1 !== 8'h00) begin
      failures++;
      $display("FAIL rst_inflight got cv=%b flags=%b a=%h required 0/0000/00",
               commit_valid, flags, alu_operand1);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ncommit = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (commit_valid === 1'b1) ncommit++;
    end
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 8'h00 || flags !== 4'b0000 || ncommit != 0) begin
      failures++;
      $display("FAIL rst_discard got r7=%h flags=%b commits=%0d required 00/0000/0",
               dbg_data, flags, ncommit);
    end
  endtask

  task automatic test_random();
    logic [7:0]  arch [8];
    logic [7:0]  committed [8];
    logic [3:0]  exp_flags;
    logic [7:0]  a, b;
    logic [11:0] res;
    logic        exp_cv;
    rec_t        rec;
    rec_t        pend[$];
    for (int i = 0; i < 8; i++) begin arch[i] = 8'h00; committed[i] = 8'h00; end
    exp_flags = 4'b0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (flags !== exp_flags) begin
        failures++; $display("FAIL rnd_flags cyc%0d got %b required %b", cyc, flags, exp_flags);
      end
      if (cyc < 590) begin
        hold     = ($urandom_range(0, 4) == 0);
        in_valid = ($urandom_range(0, 9) < 7);
      end else begin
        hold = 1'b0; in_valid = 1'b0;
      end
      in_op = 4'($urandom_range(0, 8)); in_rd = 3'($urandom); in_rs1 = 3'($urandom);
      in_rs2 = 3'($urandom); in_imm = 8'($urandom); in_use_imm = 1'($urandom);
      dbg_addr = 3'($urandom);
      #1;
      exp_cv = (pend.size() > 0) && !hold;
      checks++;
      if (dbg_data !== committed[dbg_addr] || in_ready !== !hold || commit_valid !== exp_cv) begin
        failures++;
        $display("FAIL rnd_state cyc%0d got dbg[%0d]=%h rdy=%b cv=%b required %h/%b/%b", cyc,
                 dbg_addr, dbg_data, in_ready, commit_valid, committed[dbg_addr], !hold, exp_cv);
      end
      if (exp_cv) begin
        rec = pend.pop_front();
        checks++;
        if (commit_rd !== rec.rd || commit_data !== rec.data) begin
          failures++;
          $display("FAIL rnd_commit cyc%0d got rd=%0d data=%h required rd=%0d data=%h",
                   cyc, commit_rd, commit_data, rec.rd, rec.data);
        end
        if (rec.rd != 3'd0) committed[rec.rd] = rec.data;
        exp_flags = rec.fl;
      end
      if (in_valid && !hold) begin
        a   = (in_rs1 == 3'd0) ? 8'h00 : arch[in_rs1];
        b   = in_use_imm ? in_imm : ((in_rs2 == 3'd0) ? 8'h00 : arch[in_rs2]);
        res = alu_model(in_op, a, b);
        rec.rd = in_rd; rec.data = res[7:0]; rec.fl = res[11:8];
        pend.push_back(rec);
        if (in_rd != 3'd0) arch[in_rd] = res[7:0];
      end
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== arch[i]) begin
        failures++; $display("FAIL rnd_final r%0d got %h required %h", i, dbg_data, arch[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_sub();
    test_overflow_r0();
    test_hold();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
